comparator_by_flags: RTL and testbench

Registered flag-based comparison decoder. Takes the N, C, V, Z flags produced by the ALU's subtraction A − B and reports unsigned and signed greater/less/equal relations, plus a selectable ARM-style condition-code result. It sits between the ALU flag outputs and the branch/condition logic. All outputs are registered, with one cycle of latency.

---
 rtl/comparator_flags_pkg.sv | 27 ++
 rtl/comparator_by_flags_decode.sv | 49 ++++
 rtl/comparator_by_flags.sv | 67 ++++++
 tb/tb_comparator_by_flags.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/comparator_flags_pkg.sv
// Shared types and widths for the flag-based comparison decoder.
// The condition-code encoding matches the ARM cond field.
package comparator_flags_pkg;

  localparam int COND_W = 4;
  localparam int FLAG_W = 4;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'd0,
    NE = 4'd1,
    HS = 4'd2,
    LO = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

endpackage

// File: rtl/comparator_by_flags_decode.sv
// Purely combinational decode of N/C/V/Z flags from A - B into relations
// and the selected condition code.
module flag_decode
  import comparator_flags_pkg::*;
(
  input  logic              N,
  input  logic              C,
  input  logic              V,
  input  logic              Z,
  input  logic [COND_W-1:0] cond,
  output logic              MaU,
  output logic              MiU,
  output logic              Mag,
  output logic              Min,
  output logic              Eq,
  output logic              cond_true
);

  // Impossible flag combinations are decoded as-is, with no consistency check.
  assign MaU = C & ~Z;
  assign MiU = ~C;
  assign Mag = ~Z & (N ~^ V);
  assign Min = N ^ V;
  assign Eq  = Z;

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      EQ: cond_true = Z;
      NE: cond_true = ~Z;
      HS: cond_true = C;
      LO: cond_true = ~C;
      MI: cond_true = N;
      PL: cond_true = ~N;
      VS: cond_true = V;
      VC: cond_true = ~V;
      HI: cond_true = C & ~Z;
      LS: cond_true = ~C | Z;
      GE: cond_true = N ~^ V;
      LT: cond_true = N ^ V;
      GT: cond_true = ~Z & (N ~^ V);
      LE: cond_true = Z | (N ^ V);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/comparator_by_flags.sv
// Registered flag-based comparison decoder: one cycle from flags to relations
// and condition-code result, no combinational input-to-output path.
module comparator_by_flags
  import comparator_flags_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              N,
  input  logic              C,
  input  logic              V,
  input  logic              Z,
  input  logic [COND_W-1:0] cond,
  output logic              out_valid,
  output logic              MaU,
  output logic              MiU,
  output logic              Mag,
  output logic              Min,
  output logic              Eq,
  output logic              cond_true
);

  // Handshake: in_valid qualifies N/C/V/Z/cond in the cycle it is high; there is
  // no ready, every valid input is accepted. out_valid is high for exactly the
  // cycle after an accepted input; results hold their last value otherwise.
  logic [FLAG_W-1:0] flags;
  logic              d_mau, d_miu, d_mag, d_min, d_eq, d_cond_true;

  assign flags = {N, C, V, Z};

  flag_decode u_decode (
    .N         (flags[3]),
    .C         (flags[2]),
    .V         (flags[1]),
    .Z         (flags[0]),
    .cond      (cond),
    .MaU       (d_mau),
    .MiU       (d_miu),
    .Mag       (d_mag),
    .Min       (d_min),
    .Eq        (d_eq),
    .cond_true (d_cond_true)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      MaU       <= 1'b0;
      MiU       <= 1'b0;
      Mag       <= 1'b0;
      Min       <= 1'b0;
      Eq        <= 1'b0;
      cond_true <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        MaU       <= d_mau;
        MiU       <= d_miu;
        Mag       <= d_mag;
        Min       <= d_min;
        Eq        <= d_eq;
        cond_true <= d_cond_true;
      end
    end
  end

endmodule

// File: tb/tb_comparator_by_flags.sv
// Directed-vector bench for comparator_by_flags; outputs are packed as
// {out_valid, MaU, MiU, Mag, Min, Eq, cond_true} for comparison.
module tb_comparator_by_flags;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       N, C, V, Z;
  logic [3:0] cond;
  logic       out_valid, MaU, MiU, Mag, Min, Eq, cond_true;

  int checks = 0;
  int errors = 0;

  comparator_by_flags dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .N         (N),
    .C         (C),
    .V         (V),
    .Z         (Z),
    .cond      (cond),
    .out_valid (out_valid),
    .MaU       (MaU),
    .MiU       (MiU),
    .Mag       (Mag),
    .Min       (Min),
    .Eq        (Eq),
    .cond_true (cond_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {out_valid, MaU, MiU, Mag, Min, Eq, cond_true};
  endfunction

  // Reference relations written from the meaning of each condition.
  function automatic logic [5:0] model(input logic n, c, v, z, input logic [3:0] cd);
    logic ge, hi, ct;
    ge = (n == v);
    hi = c && !z;
    case (cd)
      4'd0:  ct = z;
      4'd1:  ct = !z;
      4'd2:  ct = c;
      4'd3:  ct = !c;
      4'd4:  ct = n;
      4'd5:  ct = !n;
      4'd6:  ct = v;
      4'd7:  ct = !v;
      4'd8:  ct = hi;
      4'd9:  ct = !hi;
      4'd10: ct = ge;
      4'd11: ct = !ge;
      4'd12: ct = ge && !z;
      4'd13: ct = !(ge && !z);
      4'd14: ct = 1'b1;
      default: ct = 1'b0;
    endcase
    return {hi, !c, ge && !z, !ge, z, ct};
  endfunction

  task automatic drive(input logic vld, fn, fc, fv, fz, input logic [3:0] cd);
    @(negedge clk);
    in_valid = vld;
    N = fn; C = fc; V = fv; Z = fz;
    cond = cd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd14);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b", obs(), 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b1011000) begin
      errors++;
      $display("FAIL reset_first got=%b want=%b", obs(), 7'b1011000);
    end
  endtask

  task automatic test_flag_sweep();
    logic [3:0] vin [6];
    logic [4:0] vexp [6];
    vin[0] = 4'b1001; vexp[0] = 5'b01011;
    vin[1] = 4'b1101; vexp[1] = 5'b00011;
    vin[2] = 4'b1010; vexp[2] = 5'b01100;
    vin[3] = 4'b0001; vexp[3] = 5'b01001;
    vin[4] = 4'b0100; vexp[4] = 5'b10100;
    vin[5] = 4'b0010; vexp[5] = 5'b01010;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vin[i][3], vin[i][2], vin[i][1], vin[i][0], 4'd14);
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== {1'b1, vexp[i], 1'b1}) begin
        errors++;
        $display("FAIL flag_sweep[%0d] got=%b want=%b", i, obs(), {1'b1, vexp[i], 1'b1});
      end
    end
  endtask

  task automatic test_cond_codes();
    logic [3:0] cds [6];
    logic       cexp [6];
    cds[0] = 4'd8;  cexp[0] = 1'b1;
    cds[1] = 4'd9;  cexp[1] = 1'b0;
    cds[2] = 4'd12; cexp[2] = 1'b1;
    cds[3] = 4'd13; cexp[3] = 1'b0;
    cds[4] = 4'd14; cexp[4] = 1'b1;
    cds[5] = 4'd15; cexp[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cds[i]);
      @(posedge clk);
      #1;
      checks++;
      if (cond_true !== cexp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL cond_code[%0d] got=%b/%b want=%b/1", cds[i], cond_true, out_valid, cexp[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b1101001) begin
      errors++;
      $display("FAIL hold_load got=%b want=%b", obs(), 7'b1101001);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], !i[0], !i[0], !i[0], 4'(i + 3));
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== 7'b0101001) begin
        errors++;
        $display("FAIL hold[%0d] got=%b want=%b", i, obs(), 7'b0101001);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      drive(1'b1, v[7], v[6], v[5], v[4], v[3:0]);
      @(posedge clk);
      #1;
      checks++;
      if (obs() !== {1'b1, model(v[7], v[6], v[5], v[4], v[3:0])}) begin
        errors++;
        $display("FAIL exhaustive[%0d] got=%b want=%b", i, obs(),
                 {1'b1, model(v[7], v[6], v[5], v[4], v[3:0])});
      end
    end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL midreset_async got=%b want=%b", obs(), 7'b0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL midreset_hold got=%b want=%b", obs(), 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11);
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b1010101) begin
      errors++;
      $display("FAIL midreset_first got=%b want=%b", obs(), 7'b1010101);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    N = 1'b0; C = 1'b0; V = 1'b0; Z = 1'b0;
    cond = 4'd0;
    test_reset();
    test_flag_sweep();
    test_cond_codes();
    test_hold();
    test_exhaustive();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
